// File: rtl/btn_sw_conditioner.sv
// Button/switch front end: 2-flop synchronisers, counter-based button debounce FSM,
// single-cycle press pulse with a switch snapshot. Optional press counter: PRESS_COUNTER_EN.
module btn_sw_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_raw_i,
    input  logic [3:0] sw_raw_i,
    output logic       button_o,
    output logic [3:0] sw_o,
    output logic       btn_level_o,
    output logic [7:0] press_cnt_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARM_HIGH = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] ARM_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             btn_meta_r;
    logic             btn_sync_r;
    logic [3:0]       sw_meta_r;
    logic [3:0]       sw_sync_r;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             pulse_s;
    logic             level_nxt_s;
    logic             button_r;
    logic [3:0]       sw_r;
    logic             level_r;

    // Two-flop synchronisers for the asynchronous button and switch pins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            sw_meta_r  <= 4'd0;
            sw_sync_r  <= 4'd0;
        end else begin
            btn_meta_r <= btn_raw_i;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= sw_raw_i;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Debounce next-state logic: a level is accepted only after DEBOUNCE_CYCLES stable cycles.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pulse_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_sync_r) begin
                    state_nxt_s = ARM_HIGH;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARM_HIGH: begin
                if (!btn_sync_r) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = PRESSED;
                    pulse_s     = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_sync_r) begin
                    state_nxt_s = ARM_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            ARM_LOW: begin
                if (btn_sync_r) begin
                    state_nxt_s = PRESSED;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
        level_nxt_s = (state_nxt_s == PRESSED) || (state_nxt_s == ARM_LOW);
    end

    // FSM state, counter and registered outputs; the switch snapshot moves only on a pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            button_r <= 1'b0;
            sw_r     <= 4'd0;
            level_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            button_r <= pulse_s;
            level_r  <= level_nxt_s;
            if (pulse_s) begin
                sw_r <= sw_sync_r;
            end else begin
                sw_r <= sw_r;
            end
        end
    end

    assign button_o    = button_r;
    assign sw_o        = sw_r;
    assign btn_level_o = level_r;

`ifdef PRESS_COUNTER_EN
    logic [7:0] press_cnt_r;

    // Accepted-press counter, wraps naturally at 8 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            press_cnt_r <= 8'd0;
        end else if (pulse_s) begin
            press_cnt_r <= press_cnt_r + 8'd1;
        end else begin
            press_cnt_r <= press_cnt_r;
        end
    end

    assign press_cnt_o = press_cnt_r;
`else
    assign press_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Self-checking bench for btn_sw_conditioner with DEBOUNCE_CYCLES=4; pulses are matched
// against a queue of expected (edge, switch, count) records.
module tb_btn_sw_conditioner;

    localparam int DB = 4;

    logic       clk;
    logic       rst_n;
    logic       btn_raw;
    logic [3:0] sw_raw;
    logic       button;
    logic [3:0] sw;
    logic       btn_level;
    logic [7:0] press_cnt;

    typedef struct {
        int         edge_n;
        logic [3:0] sw;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] model_cnt = 8'd0;

    btn_sw_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .btn_raw_i   (btn_raw),
        .sw_raw_i    (sw_raw),
        .button_o    (button),
        .sw_o        (sw),
        .btn_level_o (btn_level),
        .press_cnt_o (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge index: after edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int e, input logic [3:0] s);
`ifdef PRESS_COUNTER_EN
        model_cnt = model_cnt + 8'd1;
`endif
        sb_q.push_back('{e, s, model_cnt});
    endtask

    // Scoreboard: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && button === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pulse_edge", 32'(cyc), 32'(e.edge_n));
                chk("pulse_sw", 32'(sw), 32'(e.sw));
                chk("pulse_cnt", 32'(press_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic press(input logic [3:0] s, input int hold, input int low);
        @(negedge clk);
        sw_raw  = s;
        btn_raw = 1'b1;
        push(cyc + 1 + DB + 2, s);
        repeat (hold) @(negedge clk);
        btn_raw = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    // Release drive at a negedge, then check level falls exactly DB+3 edges later.
    task automatic release_check(input string tag);
        int j;
        btn_raw = 1'b0;
        j = cyc + 1;
        repeat (DB + 6) begin
            @(negedge clk);
            chk(tag, 32'(btn_level), 32'(cyc < j + DB + 2));
        end
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        model_cnt = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        rst_n   = 1'b0;
        btn_raw = 1'b0;
        sw_raw  = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_button", 32'(button), 32'd0);
        chk("rst_sw", 32'(sw), 32'd0);
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_cnt", 32'(press_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press with sw=A, held 20 clocks.
        sw_raw  = 4'hA;
        btn_raw = 1'b1;
        k = cyc + 1;
        push(k + DB + 2, 4'hA);
        repeat (20) begin
            @(negedge clk);
            if (cyc >= k + DB + 2) chk("held_level", 32'(btn_level), 32'd1);
            else chk("arm_level", 32'(btn_level), 32'd0);
        end
        chk("clean_sw", 32'(sw), 32'hA);
        release_check("clean_release");

        // Bounce reject: five 3-clock highs with 3-clock gaps; switches change meanwhile.
        sw_raw = 4'h5;
        repeat (5) begin
            btn_raw = 1'b1;
            repeat (3) @(negedge clk);
            btn_raw = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("bounce_sw", 32'(sw), 32'hA);
        chk("bounce_level", 32'(btn_level), 32'd0);

        // Release bounce: 2-clock low dropout while pressed, then final release.
        sw_raw  = 4'h6;
        btn_raw = 1'b1;
        push(cyc + 1 + DB + 2, 4'h6);
        repeat (12) @(negedge clk);
        btn_raw = 1'b0;
        repeat (2) @(negedge clk);
        btn_raw = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("dropout_level", 32'(btn_level), 32'd1);
        end
        release_check("final_release");
        chk("rb_sw", 32'(sw), 32'h6);

        // Switch isolation after a reset.
        apply_reset();
        foreach (sw_raw[i]) begin end
        sw_raw = 4'h0;
        repeat (4) @(negedge clk);
        sw_raw = 4'hF;
        repeat (4) @(negedge clk);
        chk("iso_sw_f", 32'(sw), 32'd0);
        sw_raw = 4'h3;
        repeat (4) @(negedge clk);
        chk("iso_sw_3", 32'(sw), 32'd0);
        press(4'h3, 10, 10);
        chk("iso_after_press", 32'(sw), 32'h3);

        // Async reset while in ARM_HIGH, raw held high through reset release.
        btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        model_cnt = 8'd0;
        #1;
        chk("arst_button", 32'(button), 32'd0);
        chk("arst_sw", 32'(sw), 32'd0);
        chk("arst_level", 32'(btn_level), 32'd0);
        chk("arst_cnt", 32'(press_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push(cyc + 1 + DB + 2, 4'h3);
        repeat (12) @(negedge clk);
        release_check("arst_release");

        // Counter wrap: 257 clean presses from a freshly reset counter.
        apply_reset();
        for (int i = 0; i < 257; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            press(iv[3:0], 10, 10);
        end
`ifdef PRESS_COUNTER_EN
        chk("wrap_cnt", 32'(press_cnt), 32'd1);
`else
        chk("wrap_cnt", 32'(press_cnt), 32'd0);
`endif
        chk("wrap_model", 32'(press_cnt), 32'(model_cnt));

        repeat (10) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
